// File: rtl/acc_scheduler.sv
// Time-shares one serial accumulator among R requesters, each of which keeps its own running sum.
// Optional watchdog on the accumulator's done pulse: define ACC_SCHEDULER_TIMEOUT_EN.
module acc_scheduler #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] req_data,
    input  logic [R-1:0]   req_clr,
    output logic [R-1:0]   ack,
    output logic [N-1:0]   resp_sum,
    output logic           resp_err,
    output logic           acc_load,
    output logic [N-1:0]   acc_data,
    output logic           acc_clear,
    input  logic           acc_done,
    input  logic [N-1:0]   acc_sum
);

    localparam int GW = (R > 1) ? $clog2(R) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RESTORE = 3'd2;
    localparam logic [2:0] S_WAIT_R  = 3'd3;
    localparam logic [2:0] S_ADD     = 3'd4;
    localparam logic [2:0] S_WAIT_A  = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    logic [2:0]    r_state;
    logic [GW-1:0] r_grant;
    logic [N-1:0]  r_data;
    logic          r_clr;
    logic [N-1:0]  r_ctx [R];
    logic [GW-1:0] r_owner;
    logic          r_owner_valid;
    logic [GW-1:0] r_rr;

`ifdef ACC_SCHEDULER_TIMEOUT_EN
    // ADD/RESTORE cycle plus N+7 waiting cycles puts the error ack N+8 cycles after acc_load.
    localparam int WDW = $clog2(N + 8);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(N + 6);
    logic [WDW-1:0] r_wd;
    logic           r_err;
`endif

    logic          w_any;
    logic [GW-1:0] w_grant;
    logic [N-1:0]  w_ctx_g;

    assign w_ctx_g = r_ctx[r_grant];

    // Round-robin search starting at r_rr; walking downward lets the nearest requester win.
    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a variable unassigned (no latch).
        int idx;
        idx     = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= R) idx = idx - R;
            if (req[GW'(idx)]) begin
                w_any   = 1'b1;
                w_grant = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and the sensitivity list is clk only.
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_data        <= '0;
            r_clr         <= 1'b0;
            r_owner       <= '0;
            r_owner_valid <= 1'b0;
            r_rr          <= '0;
            // NOTE: the context array is deliberately reset; every requester must restart from zero.
            for (int i = 0; i < R; i++) r_ctx[i] <= '0;
`ifdef ACC_SCHEDULER_TIMEOUT_EN
            r_wd          <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_data  <= req_data[w_grant*N +: N];
                        r_clr   <= req_clr[w_grant];
                        r_rr    <= (w_grant == GW'(R - 1)) ? '0 : w_grant + GW'(1);
`ifdef ACC_SCHEDULER_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        if (r_owner_valid && (r_owner == w_grant) && !req_clr[w_grant])
                            r_state <= S_ADD;
                        else
                            r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_owner_valid <= 1'b0;
                    r_state       <= (!r_clr && (w_ctx_g != '0)) ? S_RESTORE : S_ADD;
                end
                S_RESTORE: begin
                    r_state <= S_WAIT_R;
`ifdef ACC_SCHEDULER_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end
                S_WAIT_R: begin
                    if (acc_done) r_state <= S_ADD;
`ifdef ACC_SCHEDULER_TIMEOUT_EN
                    else if (r_wd == WD_LIMIT) begin
                        r_owner_valid <= 1'b0;
                        r_err         <= 1'b1;
                        r_state       <= S_RESP;
                    end else r_wd <= r_wd + WDW'(1);
`endif
                end
                S_ADD: begin
                    r_state <= S_WAIT_A;
`ifdef ACC_SCHEDULER_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end
                S_WAIT_A: begin
                    if (acc_done) begin
                        r_ctx[r_grant] <= acc_sum;
                        r_owner        <= r_grant;
                        r_owner_valid  <= 1'b1;
                        r_state        <= S_RESP;
                    end
`ifdef ACC_SCHEDULER_TIMEOUT_EN
                    else if (r_wd == WD_LIMIT) begin
                        r_owner_valid <= 1'b0;
                        r_err         <= 1'b1;
                        r_state       <= S_RESP;
                    end else r_wd <= r_wd + WDW'(1);
`endif
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes, so each lasts exactly one cycle and they can never overlap.
    always_comb begin
        ack       = '0;
        resp_sum  = '0;
        acc_load  = 1'b0;
        acc_clear = 1'b0;
        acc_data  = '0;
        case (r_state)
            S_CLEAR:   acc_clear = 1'b1;
            S_RESTORE: begin
                acc_load = 1'b1;
                acc_data = w_ctx_g;
            end
            S_ADD: begin
                acc_load = 1'b1;
                acc_data = r_data;
            end
            S_RESP: begin
                ack[r_grant] = 1'b1;
                resp_sum     = w_ctx_g;
            end
            default: ;
        endcase
    end

`ifdef ACC_SCHEDULER_TIMEOUT_EN
    assign resp_err = (r_state == S_RESP) && r_err;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_scheduler.sv
// Directed bench for acc_scheduler with a behavioural serial-accumulator responder (fixed done latency).
// Timeout scenarios run only when ACC_SCHEDULER_TIMEOUT_EN is defined.
module tb_acc_scheduler;

    localparam int N   = 8;
    localparam int R   = 4;
    localparam int LAT = 2;

    typedef struct {
        int         id;
        logic [7:0] sum;
        logic       err;
        int         cyc;
    } ack_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [R-1:0]   req;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_clr;
    logic [R-1:0]   ack;
    logic [N-1:0]   resp_sum;
    logic           resp_err;
    logic           acc_load;
    logic [N-1:0]   acc_data;
    logic           acc_clear;
    logic           acc_done;
    logic [N-1:0]   acc_sum;

    int n_cmp = 0;
    int n_bad = 0;

    int         cyc = 0;
    int         clear_cnt = 0;
    int         last_load_cyc = 0;
    int         viol = 0;
    logic       prev_ack = 1'b0;
    logic [7:0] load_q[$];
    ack_t       ack_q[$];

    logic       withhold = 1'b0;
    logic [7:0] model_acc = '0;
    int         cd = 0;

    acc_scheduler #(.N(N), .R(R)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_clr(req_clr),
        .ack(ack), .resp_sum(resp_sum), .resp_err(resp_err),
        .acc_load(acc_load), .acc_data(acc_data), .acc_clear(acc_clear),
        .acc_done(acc_done), .acc_sum(acc_sum)
    );

    always #5 clk = ~clk;

    // Monitor: records strobes and acks at mid-cycle, flags overlapping strobes and back-to-back acks.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (acc_load && acc_clear) viol++;
            if (acc_clear) clear_cnt++;
            if (acc_load) begin
                load_q.push_back(acc_data);
                last_load_cyc = cyc;
            end
            if (ack != '0) begin
                ack_t a;
                a.id = -1;
                for (int i = 0; i < R; i++) if (ack[i]) a.id = i;
                a.sum = resp_sum;
                a.err = resp_err;
                a.cyc = cyc;
                if (prev_ack || !$onehot(ack)) viol++;
                ack_q.push_back(a);
            end
            prev_ack = |ack;
        end
    end

    // Accumulator model: clear zeroes, load adds, done pulses LAT cycles after a load.
    initial begin
        acc_done = 1'b0;
        acc_sum  = '0;
        forever begin
            @(negedge clk);
            acc_done = 1'b0;
            if (!reset_n) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        acc_done = 1'b1;
                        acc_sum  = model_acc;
                    end
                end
                if (acc_clear) model_acc = '0;
                if (acc_load) begin
                    model_acc = model_acc + acc_data;
                    cd = withhold ? 0 : LAT;
                end
            end
        end
    end

    task automatic txn(input int id, input logic [7:0] data, input logic clr,
                       output ack_t res, output bit ok);
        int n0;
        n0  = ack_q.size();
        ok  = 1'b0;
        res = '{id: -1, sum: '0, err: 1'b0, cyc: 0};
        req[id] = 1'b1;
        req_data[id*8 +: 8] = data;
        req_clr[id] = clr;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ack_q.size() > n0) begin
                ok  = 1'b1;
                res = ack_q[n0];
                break;
            end
        end
        req[id]     = 1'b0;
        req_clr[id] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        req_clr  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack, resp_err, acc_load, acc_clear} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got ack=%b err=%b load=%b clr=%b want all 0", ack, resp_err, acc_load, acc_clear);
        end
        n_cmp++;
        if ({resp_sum, acc_data} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_data: got resp_sum=%0d acc_data=%0d want 0 0", resp_sum, acc_data);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_add();
        ack_t r; bit ok; int c0, l0;
        c0 = clear_cnt; l0 = load_q.size();
        txn(0, 8'd5, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 0 || r.sum !== 8'd5 || r.err !== 1'b0) begin
            n_bad++;
            $display("FAIL first_add: got ok=%0d id=%0d sum=%0d err=%b want 1 0 5 0", ok, r.id, r.sum, r.err);
        end
        n_cmp++;
        if (clear_cnt - c0 !== 1 || load_q.size() - l0 !== 1 || load_q[l0] !== 8'd5) begin
            n_bad++;
            $display("FAIL first_seq: got clears=%0d loads=%0d want 1 clear, 1 load of 5", clear_cnt - c0, load_q.size() - l0);
        end
    endtask

    task automatic test_owner_hit();
        ack_t r; bit ok; int c0, l0;
        c0 = clear_cnt; l0 = load_q.size();
        txn(0, 8'd3, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 0 || r.sum !== 8'd8) begin
            n_bad++;
            $display("FAIL owner_hit_sum: got ok=%0d id=%0d sum=%0d want 1 0 8", ok, r.id, r.sum);
        end
        n_cmp++;
        if (clear_cnt != c0 || load_q.size() - l0 !== 1 || load_q[l0] !== 8'd3) begin
            n_bad++;
            $display("FAIL owner_hit_seq: got clears=%0d loads=%0d want 0 clears, 1 load of 3", clear_cnt - c0, load_q.size() - l0);
        end
    endtask

    task automatic test_restore();
        ack_t r; bit ok; int c0, l0;
        txn(1, 8'd10, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 1 || r.sum !== 8'd10) begin
            n_bad++;
            $display("FAIL restore_other: got ok=%0d id=%0d sum=%0d want 1 1 10", ok, r.id, r.sum);
        end
        c0 = clear_cnt; l0 = load_q.size();
        txn(0, 8'd1, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 0 || r.sum !== 8'd9) begin
            n_bad++;
            $display("FAIL restore_sum: got ok=%0d id=%0d sum=%0d want 1 0 9", ok, r.id, r.sum);
        end
        n_cmp++;
        if (clear_cnt - c0 !== 1 || load_q.size() - l0 !== 2 || load_q[l0] !== 8'd8 || load_q[l0+1] !== 8'd1) begin
            n_bad++;
            $display("FAIL restore_seq: got clears=%0d loads=%0d want 1 clear, loads 8 then 1", clear_cnt - c0, load_q.size() - l0);
        end
    endtask

    task automatic test_round_robin();
        int         exp_id[4]  = '{1, 2, 3, 0};
        logic [7:0] exp_sum[4] = '{8'd11, 8'd2, 8'd3, 8'd13};
        int n0, seen;
        n0 = ack_q.size();
        seen = 0;
        req_data = {8'd3, 8'd2, 8'd1, 8'd4};
        req = 4'b1111;
        for (int c = 0; c < 400 && seen < 4; c++) begin
            @(posedge clk); #1;
            while (ack_q.size() > n0 + seen) begin
                if (ack_q[n0+seen].id >= 0) req[ack_q[n0+seen].id] = 1'b0;
                seen++;
            end
        end
        req = '0;
        n_cmp++;
        if (seen != 4) begin
            n_bad++;
            $display("FAIL rr_count: got %0d acks want 4", seen);
        end
        for (int i = 0; i < seen && i < 4; i++) begin
            n_cmp++;
            if (ack_q[n0+i].id !== exp_id[i] || ack_q[n0+i].sum !== exp_sum[i]) begin
                n_bad++;
                $display("FAIL rr_ack%0d: got id=%0d sum=%0d want id=%0d sum=%0d", i, ack_q[n0+i].id, ack_q[n0+i].sum, exp_id[i], exp_sum[i]);
            end
        end
    endtask

    task automatic test_wrap_and_clr();
        ack_t r; bit ok; int c0, l0;
        txn(0, 8'd250, 1'b1, r, ok);
        n_cmp++;
        if (!ok || r.sum !== 8'd250) begin
            n_bad++;
            $display("FAIL clr_250: got ok=%0d sum=%0d want 1 250", ok, r.sum);
        end
        txn(0, 8'd10, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.sum !== 8'd4 || r.err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap: got ok=%0d sum=%0d err=%b want 1 4 0", ok, r.sum, r.err);
        end
        c0 = clear_cnt; l0 = load_q.size();
        txn(0, 8'd7, 1'b1, r, ok);
        n_cmp++;
        if (!ok || r.sum !== 8'd7) begin
            n_bad++;
            $display("FAIL clr_7: got ok=%0d sum=%0d want 1 7", ok, r.sum);
        end
        n_cmp++;
        if (clear_cnt - c0 !== 1 || load_q.size() - l0 !== 1 || load_q[l0] !== 8'd7) begin
            n_bad++;
            $display("FAIL clr_seq: got clears=%0d loads=%0d want 1 clear, 1 load of 7", clear_cnt - c0, load_q.size() - l0);
        end
    endtask

    task automatic test_drop_early();
        int n0, c0;
        bit got;
        n0 = ack_q.size(); c0 = clear_cnt; got = 1'b0;
        req[2] = 1'b1;
        req_data[23:16] = 8'd5;
        for (int c = 0; c < 50 && clear_cnt == c0; c++) begin
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk); #1;
            got = ack_q.size() > n0;
        end
        n_cmp++;
        if (!got || ack_q[n0].id !== 2 || ack_q[n0].sum !== 8'd7) begin
            n_bad++;
            $display("FAIL drop_early: got ack=%0d id=%0d sum=%0d want 1 2 7", got, got ? ack_q[n0].id : -1, got ? ack_q[n0].sum : 8'd0);
        end
    endtask

    task automatic test_reset_mid();
        ack_t r; bit ok; int n0, l0, c0;
        n0 = ack_q.size(); l0 = load_q.size();
        req[3] = 1'b1;
        req_data[31:24] = 8'd1;
        for (int c = 0; c < 50 && load_q.size() == l0; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack, resp_err, acc_load, acc_clear, resp_sum, acc_data} !== 23'h0) begin
            n_bad++;
            $display("FAIL midreset_out: got ack=%b load=%b clr=%b sum=%0d data=%0d want all 0", ack, acc_load, acc_clear, resp_sum, acc_data);
        end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (ack_q.size() != n0) begin
            n_bad++;
            $display("FAIL midreset_noack: got %0d acks want 0", ack_q.size() - n0);
        end
        c0 = clear_cnt; l0 = load_q.size();
        txn(3, 8'd1, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 3 || r.sum !== 8'd1 || clear_cnt - c0 !== 1 || load_q.size() - l0 !== 1) begin
            n_bad++;
            $display("FAIL post_reset3: got ok=%0d id=%0d sum=%0d clears=%0d loads=%0d want 1 3 1 1 1", ok, r.id, r.sum, clear_cnt - c0, load_q.size() - l0);
        end
        txn(0, 8'd4, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 0 || r.sum !== 8'd4) begin
            n_bad++;
            $display("FAIL post_reset0: got ok=%0d id=%0d sum=%0d want 1 0 4", ok, r.id, r.sum);
        end
    endtask

`ifdef ACC_SCHEDULER_TIMEOUT_EN
    task automatic test_timeout();
        ack_t r; bit ok; int n0, l0;
        withhold = 1'b1;
        txn(1, 8'd9, 1'b0, r, ok);
        n_cmp++;
        if (!ok || r.id !== 1 || r.err !== 1'b1 || r.sum !== 8'd0) begin
            n_bad++;
            $display("FAIL timeout_ack: got ok=%0d id=%0d err=%b sum=%0d want 1 1 1 0", ok, r.id, r.err, r.sum);
        end
        n_cmp++;
        if (r.cyc - last_load_cyc !== N + 8) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d cycles want %0d", r.cyc - last_load_cyc, N + 8);
        end
        n0 = ack_q.size(); l0 = load_q.size();
        req[1] = 1'b1;
        for (int c = 0; c < 50 && load_q.size() == l0; c++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ack_q.size() != n0 || {ack, resp_err, acc_load, acc_clear, resp_sum, acc_data} !== 23'h0) begin
            n_bad++;
            $display("FAIL timeout_reset: got acks=%0d ack=%b err=%b sum=%0d want 0 and all outputs 0", ack_q.size() - n0, ack, resp_err, resp_sum);
        end
        withhold = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_invariants();
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL invariants: got %0d strobe-overlap/back-to-back/non-onehot events want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_first_add();
        test_owner_hit();
        test_restore();
        test_round_robin();
        test_wrap_and_clr();
        test_drop_early();
        test_reset_mid();
`ifdef ACC_SCHEDULER_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/acc_scheduler.md
ACC_SCHEDULER -- requirements
Module: acc_scheduler

Interface
REQ-001 SHALL have parameter N, default 8: operand/sum width, matching the shared serial accumulator.
REQ-002 SHALL have parameter R, default 4: number of requesters, 2..8.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  R  per-requester add request; held until matching ack.
REQ-006 SHALL have port req_data  input  R*N  operand of requester i in bits [i*N+N-1:i*N].
REQ-007 SHALL have port req_clr  input  R  start requester's running sum from zero; sampled with req.
REQ-008 SHALL have port ack  output  R  one-hot single-cycle completion pulse.
REQ-009 SHALL have port resp_sum  output  N  requester's new running sum, valid while ack nonzero.
REQ-010 SHALL have port resp_err  output  1  error flag, valid while ack nonzero.
REQ-011 SHALL have port acc_load  output  1  load_input strobe to the accumulator.
REQ-012 SHALL have port acc_data  output  N  input_data to the accumulator.
REQ-013 SHALL have port acc_clear  output  1  clear_acc strobe to the accumulator.
REQ-014 SHALL have port acc_done  input  1  done pulse from the accumulator.
REQ-015 SHALL have port acc_sum  input  N  sum_out from the accumulator.

Function
REQ-016 SHALL keep one N-bit context register per requester holding its running sum, plus owner id and owner_valid for the accumulator's current contents.
REQ-017 SHALL use FSM states IDLE, CLEAR, RESTORE, WAIT_R, ADD, WAIT_A, RESP.
REQ-018 SHALL, in IDLE with any req, grant round-robin starting at the requester after the last granted one; latch grant id, data, clr.
REQ-019 SHALL go IDLE->ADD when owner_valid, grant==owner and clr=0; otherwise IDLE->CLEAR.
REQ-020 SHALL in CLEAR assert acc_clear one cycle; next RESTORE if clr=0 and ctx[grant]!=0, else ADD.
REQ-021 SHALL in RESTORE assert acc_load one cycle with acc_data=ctx[grant], then WAIT_R until acc_done, then ADD.
REQ-022 SHALL in ADD assert acc_load one cycle with acc_data=latched operand, then WAIT_A until acc_done.
REQ-023 SHALL on acc_done in WAIT_A write acc_sum to ctx[grant] (or zero then sum if clr), set owner=grant, owner_valid=1, go RESP.
REQ-024 SHALL in RESP pulse ack[grant] one cycle with resp_sum=ctx[grant], resp_err=0, then IDLE; never ack in consecutive cycles.
REQ-025 SHALL hold acc_load and acc_clear low outside the single cycles above; never assert both together.
REQ-026 SHALL compute sums modulo 2^N; carry-out discarded, no error.
REQ-027 SHALL ignore req changes and acc_done outside WAIT_R/WAIT_A; a requester dropping req before ack is still acked.

Reset
REQ-028 SHALL on clk edge with reset_n=0: state IDLE, all ctx=0, owner_valid=0, rr pointer to requester 0, ack=0, resp_sum=0, resp_err=0, acc_load=0, acc_clear=0, acc_data=0.
REQ-029 SHALL abandon any operation on reset mid-transaction without ack; first post-reset grant always passes CLEAR.

Configuration
REQ-030 SHALL, with ACC_SCHEDULER_TIMEOUT_EN defined, run a watchdog in WAIT_R/WAIT_A; if acc_done absent for N+8 cycles after acc_load, set owner_valid=0, leave ctx[grant] unchanged, pulse ack[grant] with resp_err=1, resp_sum=ctx[grant], return IDLE.
REQ-031 SHALL, without ACC_SCHEDULER_TIMEOUT_EN, wait indefinitely for acc_done; resp_err tied 0.

Verification
REQ-032 SHALL cover: after reset, req[0], data=5 -> CLEAR, ADD, ack[0] with resp_sum=5; ctx0=5.
REQ-033 SHALL cover: req[0] data=3 again -> no CLEAR, no RESTORE; resp_sum=8.
REQ-034 SHALL cover: req[1] data=10 then req[0] data=1 -> second grant does CLEAR, RESTORE(8), ADD; resp_sum=9; req[1] gets 10.
REQ-035 SHALL cover: req=4'b1111 simultaneously -> acks in order 1,2,3,0 when last grant was 0.
REQ-036 SHALL cover: ctx0=250, data=10 -> resp_sum=4 (wrap); then req_clr with data=7 -> resp_sum=7.
REQ-037 SHALL cover: with ACC_SCHEDULER_TIMEOUT_EN, acc_done withheld -> ack with resp_err=1 exactly N+8 cycles after acc_load; reset_n=0 in WAIT_A -> no ack, all outputs zero.
